mainbus_sequencer: RTL and testbench
====================================

Name: mainbus_sequencer

Overview:
Command-side encoder for the JAM-1 main bus. Accepts queued high-level transfer commands (register move, 16-bit transfer-bus move, memory read, memory write) and emits the encoded per-cycle control fields: MainBus assert/load codes, Xfer assert/load codes, AddrSel, and memory direction. These are the fields the bus control decoder expands into per-device strobes. Memory operations stall on Memory_Ack, with a timeout.

Parameters:
FIFO_DEPTH, 4, command queue entries (power of two, ≥2)
ACK_TIMEOUT, 15, max wait cycles for mem_ack before abort (≥1)

Ports:
clk  in  1  system clock, rising edge
reset_in  in  1  asynchronous, active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  queue can accept (= not full)
cmd_op  in  2  0 MOVE, 1 XFER16, 2 MEMRD, 3 MEMWR
cmd_src  in  4  source code (MOVE/XFER16/MEMWR: data source; MEMRD: address pointer)
cmd_dst  in  4  dest code (MOVE/XFER16/MEMRD: data dest; MEMWR: address pointer)
mem_ack  in  1  memory completion, single-cycle pulse
mainbus_assert  out  4  MainBus assert code, 0 = none
mainbus_load  out  4  MainBus load code, 0 = none
xfer_assert  out  3  Xfer assert code, 0 = none
xfer_loaddec  out  4  Xfer load/dec code, 0 = none
addr_sel  out  3  address pointer select, 0 = none
mem_dir  out  1  1 = write, 0 = read; meaningful only while addr_sel≠0
busy  out  1  queue non-empty or FSM not IDLE
err  out  1  sticky: illegal command dropped or ack timeout; cleared only by reset

Behaviour:
- Reset (reset_in low, async): FIFO empty; FSM IDLE; all code outputs 0; mem_dir 0; busy 0; err 0; cmd_ready 1 once released.
- Push: when cmd_valid && cmd_ready. Pop: when FSM is IDLE or finishing an op, and the queue is non-empty.
  - Push and pop in the same cycle are allowed when not full.
  - When full, the push is refused (ready low) even if a pop occurs that cycle.
- Output registers: all code outputs are registered. Each output cycle is the cycle after the command is popped; a command pushed into an empty idle queue reaches the outputs 2 cycles later.
- Legality checks at pop:
  - MOVE: src 1..15 and dst 1..8.
  - XFER16: src 1..7 and dst 1..15.
  - MEMRD: src 1..7 and dst 1..8.
  - MEMWR: src 1..15 and dst 1..7.
  - On failure: the command is dropped, err is set, and no output cycle is produced.
- FSM states: IDLE, ISSUE, MEM_WAIT, MEM_DONE.
  - MOVE: ISSUE for 1 cycle, mainbus_assert=src, mainbus_load=dst. Then IDLE, or the next command back-to-back.
  - XFER16: ISSUE for 1 cycle, xfer_assert=src, xfer_loaddec=dst.
  - MEMWR:
    - ISSUE: mainbus_assert=src, mainbus_load=LD_MEMBRIDGE, addr_sel=dst, mem_dir=1.
    - MEM_WAIT: addr_sel/mem_dir held, bus codes 0.
  - MEMRD:
    - MEM_WAIT: addr_sel=src, mem_dir=0, bus codes 0.
    - On mem_ack → MEM_DONE for 1 cycle: mainbus_assert=AS_MEMBRIDGE, mainbus_load=dst, addr_sel still=src.
  - MEM_WAIT ack handling:
    - A wait counter starts at 0 on entry.
    - On mem_ack: MEMWR → IDLE/next; MEMRD → MEM_DONE.
    - If the counter reaches ACK_TIMEOUT without ack: set err, all outputs 0 next cycle, → IDLE/next; no load of dst.
  - mem_ack outside MEM_WAIT is ignored.
  - If mem_ack arrives in the same cycle as MEM_WAIT entry, it is not counted; ack is sampled only while registered state = MEM_WAIT.
- Back-to-back: non-memory ops sustain 1 command/cycle with no bubble.
- Mid-operation reset: outputs go to 0 immediately (async). The queued commands are lost.

Decomposition:
- Package mainbus_pkg holds:
  - op enum
  - AS_* assert codes: 1 A, 2 B, 3 C, 4 D, 5 CONST, 6 TL, 7 TH, 8 MEMBRIDGE, 9 ALU, 10–15 DEV9–14
  - LD_* load codes: 1 A, 2 B, 3 C, 4 D, 5 TL, 6 TH, 7 MEMBRIDGE, 8 CONST
  - XFER/ADDR codes: 1 PCRA0, 2 PCRA1, 3 SP, 4 SI, 5 DI, 6 TX, 7 rsvd
  - FSM state enum
  - legality-range constants
- One sub-module: mainbus_cmd_fifo (sync FIFO, FIFO_DEPTH × 10 bits, full/empty flags).

Test Plan:
- MOVE src=1 dst=4 pushed into idle block → 2 cycles later mainbus_assert=1, mainbus_load=4 for exactly 1 cycle; busy falls the next cycle.
- Four MOVEs pushed back-to-back → four consecutive issue cycles; cmd_ready stays high; a 5th push while full with a pending pop is refused.
- MEMRD src=3 dst=2, mem_ack after 5 cycles → addr_sel=3, mem_dir=0 throughout; then one cycle with assert=8, load=2; err stays 0.
- MEMWR src=5 dst=4, no ack → write-issue cycle, then addr_sel=4 held for 15 cycles, then all outputs 0 and err=1; the following queued MOVE still executes.
- Illegal MOVE dst=12 followed by a legal XFER16 src=2 dst=3 → no output for the first; err=1; xfer_assert=2, xfer_loaddec=3 next.
- reset_in pulsed low during MEM_WAIT with 2 commands queued → outputs 0 asynchronously; after release busy=0, queue empty, err=0.

Source files
------------

// File: rtl/mainbus_pkg.sv
// mainbus_pkg: shared types and code tables for the JAM-1 main bus command sequencer.
//   op_e     - queued command opcode
//   AS_*     - MainBus assert codes, LD_* - MainBus load codes
//   XA_*     - Xfer / address-pointer codes
//   state_e  - sequencer FSM states
//   cmd_t    - queued command record {op, src, dst}
//   cmd_legal() - source/destination range check applied when a command is popped
package mainbus_pkg;

  typedef enum logic [1:0] {
    OpMove   = 2'd0,
    OpXfer16 = 2'd1,
    OpMemRd  = 2'd2,
    OpMemWr  = 2'd3
  } op_e;

  localparam logic [3:0] AS_NONE      = 4'd0;
  localparam logic [3:0] AS_A         = 4'd1;
  localparam logic [3:0] AS_B         = 4'd2;
  localparam logic [3:0] AS_C         = 4'd3;
  localparam logic [3:0] AS_D         = 4'd4;
  localparam logic [3:0] AS_CONST     = 4'd5;
  localparam logic [3:0] AS_TL        = 4'd6;
  localparam logic [3:0] AS_TH        = 4'd7;
  localparam logic [3:0] AS_MEMBRIDGE = 4'd8;
  localparam logic [3:0] AS_ALU       = 4'd9;
  localparam logic [3:0] AS_DEV9      = 4'd10;
  localparam logic [3:0] AS_DEV14     = 4'd15;

  localparam logic [3:0] LD_NONE      = 4'd0;
  localparam logic [3:0] LD_A         = 4'd1;
  localparam logic [3:0] LD_B         = 4'd2;
  localparam logic [3:0] LD_C         = 4'd3;
  localparam logic [3:0] LD_D         = 4'd4;
  localparam logic [3:0] LD_TL        = 4'd5;
  localparam logic [3:0] LD_TH        = 4'd6;
  localparam logic [3:0] LD_MEMBRIDGE = 4'd7;
  localparam logic [3:0] LD_CONST     = 4'd8;

  localparam logic [2:0] XA_NONE  = 3'd0;
  localparam logic [2:0] XA_PCRA0 = 3'd1;
  localparam logic [2:0] XA_PCRA1 = 3'd2;
  localparam logic [2:0] XA_SP    = 3'd3;
  localparam logic [2:0] XA_SI    = 3'd4;
  localparam logic [2:0] XA_DI    = 3'd5;
  localparam logic [2:0] XA_TX    = 3'd6;
  localparam logic [2:0] XA_RSVD  = 3'd7;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StMemWait = 2'd2,
    StMemDone = 2'd3
  } state_e;

  typedef struct packed {
    op_e        op;
    logic [3:0] src;
    logic [3:0] dst;
  } cmd_t;

  localparam int unsigned CMD_W = $bits(cmd_t);

  // Every field must be non-zero (0 means "none") and within the op's range.
  localparam logic [3:0] CODE_MIN      = 4'd1;
  localparam logic [3:0] MOVE_SRC_MAX  = 4'd15;
  localparam logic [3:0] MOVE_DST_MAX  = 4'd8;
  localparam logic [3:0] XFER_SRC_MAX  = 4'd7;
  localparam logic [3:0] XFER_DST_MAX  = 4'd15;
  localparam logic [3:0] MEMRD_SRC_MAX = 4'd7;
  localparam logic [3:0] MEMRD_DST_MAX = 4'd8;
  localparam logic [3:0] MEMWR_SRC_MAX = 4'd15;
  localparam logic [3:0] MEMWR_DST_MAX = 4'd7;

  function automatic logic cmd_legal(cmd_t c);
    logic [3:0] s_max;
    logic [3:0] d_max;
    s_max = MOVE_SRC_MAX;
    d_max = MOVE_DST_MAX;
    unique case (c.op)
      OpMove:   begin s_max = MOVE_SRC_MAX;  d_max = MOVE_DST_MAX;  end
      OpXfer16: begin s_max = XFER_SRC_MAX;  d_max = XFER_DST_MAX;  end
      OpMemRd:  begin s_max = MEMRD_SRC_MAX; d_max = MEMRD_DST_MAX; end
      OpMemWr:  begin s_max = MEMWR_SRC_MAX; d_max = MEMWR_DST_MAX; end
      default:  ;
    endcase
    return (c.src >= CODE_MIN) && (c.src <= s_max) && (c.dst >= CODE_MIN) && (c.dst <= d_max);
  endfunction

endpackage

// File: rtl/mainbus_cmd_fifo.sv
// mainbus_cmd_fifo: synchronous FIFO for queued bus commands.
//   i_clk, i_rst_n - clock, async active-low reset
//   i_push/i_data  - write (ignored when full)
//   i_pop/o_data   - read (o_data is the head entry, ignored when empty)
//   o_full/o_empty - occupancy flags
module mainbus_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // Extra MSB distinguishes full from empty when the indices match.
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/mainbus_sequencer.sv
// mainbus_sequencer: turns queued transfer commands into registered per-cycle bus control codes.
//   clk, reset_in                 - clock, async active-low reset
//   cmd_valid/cmd_ready           - command queue handshake
//   cmd_op, cmd_src, cmd_dst      - command fields
//   mem_ack                       - memory completion pulse
//   mainbus_assert/mainbus_load   - MainBus codes
//   xfer_assert/xfer_loaddec      - Xfer bus codes
//   addr_sel, mem_dir             - memory address pointer and direction (1 = write)
//   busy, err                     - activity flag, sticky error
module mainbus_sequencer
  import mainbus_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset_in,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_src,
  input  logic [3:0] cmd_dst,
  input  logic       mem_ack,
  output logic [3:0] mainbus_assert,
  output logic [3:0] mainbus_load,
  output logic [2:0] xfer_assert,
  output logic [3:0] xfer_loaddec,
  output logic [2:0] addr_sel,
  output logic       mem_dir,
  output logic       busy,
  output logic       err
);

  localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_e           r_state;
  op_e              r_op;
  logic [3:0]       r_dst;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_mb_assert;
  logic [3:0]       r_mb_load;
  logic [2:0]       r_xa;
  logic [3:0]       r_xl;
  logic [2:0]       r_addr;
  logic             r_dir;
  logic             r_err;

  logic [CMD_W-1:0] w_head_bits;
  cmd_t             w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_pop;

  mainbus_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (reset_in),
    .i_push  (cmd_valid),
    .i_data  ({cmd_op, cmd_src, cmd_dst}),
    .i_pop   (w_pop),
    .o_data  (w_head_bits),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head = cmd_t'(w_head_bits);

  // The FSM can take a new command when idle or in the last cycle of the current op.
  // A timeout is deliberately excluded so that one all-zero cycle follows the abort.
  always_comb begin
    w_accept = 1'b0;
    unique case (r_state)
      StIdle:    w_accept = 1'b1;
      StIssue:   w_accept = (r_op != OpMemWr);
      StMemWait: w_accept = mem_ack && (r_op == OpMemWr);
      StMemDone: w_accept = 1'b1;
      default:   w_accept = 1'b0;
    endcase
  end

  assign w_pop = w_accept && !w_empty;

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      r_state     <= StIdle;
      r_op        <= OpMove;
      r_dst       <= '0;
      r_cnt       <= '0;
      r_mb_assert <= '0;
      r_mb_load   <= '0;
      r_xa        <= '0;
      r_xl        <= '0;
      r_addr      <= '0;
      r_dir       <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_accept) begin
      r_state     <= StIdle;
      r_mb_assert <= '0;
      r_mb_load   <= '0;
      r_xa        <= '0;
      r_xl        <= '0;
      r_addr      <= '0;
      r_dir       <= 1'b0;
      if (!w_empty) begin
        if (!cmd_legal(w_head)) begin
          r_err <= 1'b1;
        end else begin
          r_op  <= w_head.op;
          r_dst <= w_head.dst;
          r_cnt <= '0;
          unique case (w_head.op)
            OpMove: begin
              r_state     <= StIssue;
              r_mb_assert <= w_head.src;
              r_mb_load   <= w_head.dst;
            end
            OpXfer16: begin
              r_state <= StIssue;
              r_xa    <= w_head.src[2:0];
              r_xl    <= w_head.dst;
            end
            OpMemRd: begin
              r_state <= StMemWait;
              r_addr  <= w_head.src[2:0];
            end
            OpMemWr: begin
              r_state     <= StIssue;
              r_mb_assert <= w_head.src;
              r_mb_load   <= LD_MEMBRIDGE;
              r_addr      <= w_head.dst[2:0];
              r_dir       <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end else begin
      unique case (r_state)
        // Only a memory write stays here: drop the bus codes, keep the address.
        StIssue: begin
          r_state     <= StMemWait;
          r_cnt       <= '0;
          r_mb_assert <= '0;
          r_mb_load   <= '0;
        end
        StMemWait: begin
          if (mem_ack) begin
            r_state     <= StMemDone;
            r_mb_assert <= AS_MEMBRIDGE;
            r_mb_load   <= r_dst;
          end else if (r_cnt == CNT_LAST) begin
            r_state     <= StIdle;
            r_err       <= 1'b1;
            r_mb_assert <= '0;
            r_mb_load   <= '0;
            r_xa        <= '0;
            r_xl        <= '0;
            r_addr      <= '0;
            r_dir       <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready      = !w_full;
  assign busy           = !w_empty || (r_state != StIdle);
  assign err            = r_err;
  assign mainbus_assert = r_mb_assert;
  assign mainbus_load   = r_mb_load;
  assign xfer_assert    = r_xa;
  assign xfer_loaddec   = r_xl;
  assign addr_sel       = r_addr;
  assign mem_dir        = r_dir;

endmodule

// File: tb/tb_mainbus_sequencer.sv
// tb_mainbus_sequencer: directed, table-driven bench for mainbus_sequencer.
// Each step checks the outputs at the falling edge, then drives that cycle's inputs.
module tb_mainbus_sequencer;

  localparam logic [1:0] MV = 2'd0;
  localparam logic [1:0] XF = 2'd1;
  localparam logic [1:0] RD = 2'd2;
  localparam logic [1:0] WR = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [1:0] op;
    logic [3:0] src;
    logic [3:0] dst;
    logic       ack;
  } in_t;

  typedef struct packed {
    logic       ready;
    logic [3:0] mba;
    logic [3:0] mbl;
    logic [2:0] xa;
    logic [3:0] xl;
    logic [2:0] addr;
    logic       dir;
    logic       busy;
    logic       err;
  } out_t;

  typedef struct {
    in_t  in;
    out_t exp;
  } vec_t;

  logic       clk;
  logic       reset_in;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_src;
  logic [3:0] cmd_dst;
  logic       mem_ack;
  logic [3:0] mainbus_assert;
  logic [3:0] mainbus_load;
  logic [2:0] xfer_assert;
  logic [3:0] xfer_loaddec;
  logic [2:0] addr_sel;
  logic       mem_dir;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;

  mainbus_sequencer #(
    .FIFO_DEPTH  (4),
    .ACK_TIMEOUT (15)
  ) dut (
    .clk            (clk),
    .reset_in       (reset_in),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_src        (cmd_src),
    .cmd_dst        (cmd_dst),
    .mem_ack        (mem_ack),
    .mainbus_assert (mainbus_assert),
    .mainbus_load   (mainbus_load),
    .xfer_assert    (xfer_assert),
    .xfer_loaddec   (xfer_loaddec),
    .addr_sel       (addr_sel),
    .mem_dir        (mem_dir),
    .busy           (busy),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t I(logic v, logic [1:0] op, logic [3:0] s, logic [3:0] d, logic a);
    I = '{valid: v, op: op, src: s, dst: d, ack: a};
  endfunction

  function automatic out_t O(logic rdy, logic [3:0] mba, logic [3:0] mbl, logic [2:0] xa,
                             logic [3:0] xl, logic [2:0] addr, logic dir, logic bsy, logic e);
    O = '{ready: rdy, mba: mba, mbl: mbl, xa: xa, xl: xl, addr: addr, dir: dir, busy: bsy,
          err: e};
  endfunction

  function automatic vec_t V(in_t i, out_t o);
    V = '{in: i, exp: o};
  endfunction

  function automatic string fmt(out_t o);
    return $sformatf("rdy=%0d as=%0d ld=%0d xa=%0d xl=%0d addr=%0d dir=%0d busy=%0d err=%0d",
                     o.ready, o.mba, o.mbl, o.xa, o.xl, o.addr, o.dir, o.busy, o.err);
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = {cmd_ready, mainbus_assert, mainbus_load, xfer_assert, xfer_loaddec, addr_sel,
           mem_dir, busy, err};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %s, expected %s", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic drive(input in_t in);
    cmd_valid = in.valid;
    cmd_op    = in.op;
    cmd_src   = in.src;
    cmd_dst   = in.dst;
    mem_ack   = in.ack;
  endtask

  task automatic step(input string name, input in_t in, input out_t exp);
    @(negedge clk);
    check(name, exp);
    drive(in);
  endtask

  vec_t tbl[$];
  in_t  nop;

  initial begin
    nop = I(1'b0, MV, 4'd0, 4'd0, 1'b0);
    reset_in = 1'b0;
    drive(nop);
    #1;
    check("reset_state", O(1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    @(negedge clk);
    reset_in = 1'b1;

    // Single MOVE, four back-to-back MOVEs, then queue filled behind a MEMWR wait.
    tbl.push_back(V(I(1, MV, 1, 4, 0), O(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(V(nop,               O(1, 0, 0, 0, 0, 0, 0, 1, 0)));
    tbl.push_back(V(nop,               O(1, 1, 4, 0, 0, 0, 0, 1, 0)));
    tbl.push_back(V(I(1, MV, 2, 1, 0), O(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(V(I(1, MV, 3, 2, 0), O(1, 0, 0, 0, 0, 0, 0, 1, 0)));
    tbl.push_back(V(I(1, MV, 4, 3, 0), O(1, 2, 1, 0, 0, 0, 0, 1, 0)));
    tbl.push_back(V(I(1, MV, 9, 8, 0), O(1, 3, 2, 0, 0, 0, 0, 1, 0)));
    tbl.push_back(V(nop,               O(1, 4, 3, 0, 0, 0, 0, 1, 0)));
    tbl.push_back(V(nop,               O(1, 9, 8, 0, 0, 0, 0, 1, 0)));
    tbl.push_back(V(I(1, WR, 1, 3, 0), O(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(V(nop,               O(1, 0, 0, 0, 0, 0, 0, 1, 0)));
    tbl.push_back(V(I(1, MV, 1, 1, 0), O(1, 1, 7, 0, 0, 3, 1, 1, 0)));
    tbl.push_back(V(I(1, MV, 2, 2, 0), O(1, 0, 0, 0, 0, 3, 1, 1, 0)));
    tbl.push_back(V(I(1, MV, 3, 3, 0), O(1, 0, 0, 0, 0, 3, 1, 1, 0)));
    tbl.push_back(V(I(1, MV, 4, 4, 0), O(1, 0, 0, 0, 0, 3, 1, 1, 0)));
    // Full with a pop in the same cycle: this fifth push must be refused.
    tbl.push_back(V(I(1, MV, 5, 5, 1), O(0, 0, 0, 0, 0, 3, 1, 1, 0)));
    tbl.push_back(V(nop,               O(1, 1, 1, 0, 0, 0, 0, 1, 0)));
    tbl.push_back(V(nop,               O(1, 2, 2, 0, 0, 0, 0, 1, 0)));
    tbl.push_back(V(nop,               O(1, 3, 3, 0, 0, 0, 0, 1, 0)));
    tbl.push_back(V(nop,               O(1, 4, 4, 0, 0, 0, 0, 1, 0)));
    tbl.push_back(V(nop,               O(1, 0, 0, 0, 0, 0, 0, 0, 0)));

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("table[%0d]", i), tbl[i].in, tbl[i].exp);
    end

    // MEMRD src=3 dst=2; stray acks while idle and in MEM_DONE are ignored.
    step("rd_push", I(1, RD, 3, 2, 0), O(1, 0, 0, 0, 0, 0, 0, 0, 0));
    step("rd_idle_ack", I(0, MV, 0, 0, 1), O(1, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 4; i++) begin
      step($sformatf("rd_wait[%0d]", i), nop, O(1, 0, 0, 0, 0, 3, 0, 1, 0));
    end
    step("rd_wait_ack", I(0, MV, 0, 0, 1), O(1, 0, 0, 0, 0, 3, 0, 1, 0));
    step("rd_done", I(0, MV, 0, 0, 1), O(1, 8, 2, 0, 0, 3, 0, 1, 0));
    step("rd_idle", nop, O(1, 0, 0, 0, 0, 0, 0, 0, 0));

    // MEMWR src=5 dst=4 with no ack: 15 wait cycles, abort, then the queued MOVE.
    step("wr_push", I(1, WR, 5, 4, 0), O(1, 0, 0, 0, 0, 0, 0, 0, 0));
    step("wr_push_mv", I(1, MV, 6, 5, 0), O(1, 0, 0, 0, 0, 0, 0, 1, 0));
    step("wr_issue", nop, O(1, 5, 7, 0, 0, 4, 1, 1, 0));
    for (int i = 0; i < 15; i++) begin
      step($sformatf("wr_wait[%0d]", i), nop, O(1, 0, 0, 0, 0, 4, 1, 1, 0));
    end
    step("wr_timeout", nop, O(1, 0, 0, 0, 0, 0, 0, 1, 1));
    step("wr_next_mv", nop, O(1, 6, 5, 0, 0, 0, 0, 1, 1));
    step("wr_idle", nop, O(1, 0, 0, 0, 0, 0, 0, 0, 1));

    // Reset during MEM_WAIT with two commands queued.
    step("rst_push_rd", I(1, RD, 1, 1, 0), O(1, 0, 0, 0, 0, 0, 0, 0, 1));
    step("rst_push_mv1", I(1, MV, 2, 2, 0), O(1, 0, 0, 0, 0, 0, 0, 1, 1));
    step("rst_push_mv2", I(1, MV, 3, 3, 0), O(1, 0, 0, 0, 0, 1, 0, 1, 1));
    step("rst_wait", nop, O(1, 0, 0, 0, 0, 1, 0, 1, 1));
    #2;
    reset_in = 1'b0;
    #1;
    check("rst_async", O(1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("rst_held", O(1, 0, 0, 0, 0, 0, 0, 0, 0));
    reset_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step($sformatf("rst_after[%0d]", i), nop, O(1, 0, 0, 0, 0, 0, 0, 0, 0));
    end

    // Illegal MOVE dst=12, legal XFER16, boundary XFER16 7/15, illegal MEMWR dst=8.
    step("ill_push_mv", I(1, MV, 1, 12, 0), O(1, 0, 0, 0, 0, 0, 0, 0, 0));
    step("ill_push_xf", I(1, XF, 2, 3, 0), O(1, 0, 0, 0, 0, 0, 0, 1, 0));
    step("ill_dropped", nop, O(1, 0, 0, 0, 0, 0, 0, 1, 1));
    step("ill_xf", I(1, XF, 7, 15, 0), O(1, 0, 0, 2, 3, 0, 0, 1, 1));
    step("ill_push_wr", I(1, WR, 15, 8, 0), O(1, 0, 0, 0, 0, 0, 0, 1, 1));
    step("ill_xf_max", nop, O(1, 0, 0, 7, 15, 0, 0, 1, 1));
    step("ill_wr_drop", nop, O(1, 0, 0, 0, 0, 0, 0, 0, 1));
    step("ill_idle", nop, O(1, 0, 0, 0, 0, 0, 0, 0, 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
